mult8_seq_unit: RTL
===================

// Module: mult8_seq_unit
// PURPOSE
//  Sequential unsigned multiplier consuming WIDTH x WIDTH operands over STEPS cycles via radix-2^BITS_PER_STEP partial products.
//  Operand side is a valid/ready responder; result side is a valid/ready initiator.
//  Sits between the operand source and result sink of the 8-bit multiplier subsystem.
//  Owns its step counting internally.
// PARAMETERS
//  WIDTH          8  operand width in bits; product is 2*WIDTH
//  BITS_PER_STEP  2  multiplier bits consumed per cycle; WIDTH % BITS_PER_STEP must be 0
//  (derived) STEPS = WIDTH/BITS_PER_STEP = 4; CNT_W = $clog2(STEPS+1)
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operand pair a,b valid
//  in_ready   out  1        unit can accept operands (high only in IDLE)
//  a          in   WIDTH    multiplicand, unsigned
//  b          in   WIDTH    multiplier, unsigned
//  out_valid  out  1        product valid (high only in DONE)
//  out_ready  in   1        sink accepts product
//  product    out  2*WIDTH  a*b, unsigned, held stable while out_valid
//  busy       out  1        high in CALC or DONE
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, step=0, acc=0, product=0, in_ready=1, out_valid=0, busy=0.
//  States: IDLE -> CALC -> DONE -> IDLE; encoding 2 bits, IDLE=00, CALC=01, DONE=10, 11 -> IDLE.
//  IDLE: in_ready=1. Edge with in_valid=1: latch a_r=a, b_r=b, acc=0, step=0, -> CALC.
//   Edge with in_valid=0: remain.
//  CALC: each edge acc += (a_r * digit) << (step*BITS_PER_STEP),
//   digit = b_r[step*BITS_PER_STEP +: BITS_PER_STEP]; step++.
//   Edge where step==STEPS-1: final add, product<=acc result, step<=0, -> DONE.
//  Arithmetic: acc is 2*WIDTH bits; partial product WIDTH+BITS_PER_STEP bits zero-extended; no overflow possible.
//  Latency: operands accepted at edge T; out_valid=1 after edge T+STEPS (4 for defaults).
//  DONE: out_valid=1, product stable. Edge with out_ready=1: -> IDLE, out_valid=0.
//   product keeps last value until next DONE or reset.
//  out_ready already high when DONE entered: exactly one out_valid cycle.
//  No bypass: in_ready=0 in DONE even if out_ready=1; new operand accepted earliest one cycle after handshake.
//  in_valid during CALC/DONE ignored, no latching, no error.
//  a or b changing after acceptance has no effect (registered).
//  out_ready outside DONE ignored.
//  rst mid-CALC or mid-DONE: full reset values next cycle, in-flight result discarded.
//  rst dominates all other inputs on the same edge.
// STRUCTURE
//  Shared package mult8_pkg: state enum/localparams (ST_IDLE/ST_CALC/ST_DONE), default WIDTH, BITS_PER_STEP.
//  Sub-module mult_step_cnt: CNT_W-bit counter, inputs clk, rst, clr, en;
//   output cnt and last (cnt==STEPS-1); wraps to 0 on en&&last.
//  Top holds FSM, operand registers, accumulator and output register.
// TESTING
//  1. rst 2 cycles, a=200 b=150 in_valid 1 cycle, out_ready=1 -> out_valid 4 cycles later for 1 cycle, product=30000 (0x7530).
//  2. a=255 b=255 -> product=65025 (0xFE01); a=0 b=0xAB -> product=0; a=1 b=1 -> product=1.
//  3. Back-pressure: out_ready=0 for 5 cycles after out_valid -> product/out_valid held;
//     out_ready=1 -> IDLE next cycle, in_ready=1.
//  4. in_valid=1 with a=3 b=3 during CALC of 7*9 -> ignored, product=63, in_ready=0 throughout.
//  5. rst asserted on 2nd CALC cycle -> next cycle IDLE, product=0, out_valid=0;
//     then 12*12 -> product=144.
//  6. Back-to-back: in_valid held high, out_ready=1 -> accept every STEPS+2 cycles, all products correct vs reference model (1000 random pairs).

Source files
------------

// File: rtl/mult8_pkg.sv
// -----------------------------------------------------------------------------
// mult8_pkg
//   Shared definitions for the sequential 8-bit multiplier subsystem:
//   default operand width, multiplier bits retired per cycle, and the
//   controller state encoding.
// -----------------------------------------------------------------------------
package mult8_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MULT_WIDTH = 8;

  // Multiplier bits consumed per CALC cycle. MULT_WIDTH must be a multiple.
  localparam int MULT_BPS = 2;

  // Controller states. The unused code 2'b11 falls back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : mult8_pkg

// File: rtl/mult_step_cnt.sv
// -----------------------------------------------------------------------------
// mult_step_cnt
//   Step counter for the sequential multiplier. It counts CALC cycles and
//   flags the final step so that the controller can leave CALC.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, clears the count
//   clr   in   synchronous clear (operand acceptance)
//   en    in   advance by one step
//   cnt   out  current step index, 0 .. STEPS-1
//   last  out  high when cnt == STEPS-1
// -----------------------------------------------------------------------------
module mult_step_cnt #(
  parameter int STEPS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  output logic [$clog2(STEPS+1)-1:0] cnt,
  output logic                       last
);

  localparam int CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0] cnt_q;

  // Step register: reset/clear to zero, advance on en, wrap after the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (en) begin
      if (last) begin
        cnt_q <= {CNT_W{1'b0}};
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign last = (cnt_q == CNT_W'(STEPS - 1));
  assign cnt  = cnt_q;

endmodule : mult_step_cnt

// File: rtl/mult8_seq_unit.sv
// -----------------------------------------------------------------------------
// mult8_seq_unit
//   Sequential unsigned multiplier. An operand pair is accepted with a
//   valid/ready handshake, the product is built over STEPS cycles by adding
//   one radix-2^BITS_PER_STEP partial product per cycle, and the result is
//   offered with a valid/ready handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair a/b valid
//   in_ready   out  operands can be accepted (IDLE only)
//   a          in   multiplicand, unsigned, WIDTH bits
//   b          in   multiplier, unsigned, WIDTH bits
//   out_valid  out  product valid (DONE only)
//   out_ready  in   sink accepts product
//   product    out  a*b, 2*WIDTH bits, held until the next result or reset
//   busy       out  high while a multiplication is in CALC or DONE
// -----------------------------------------------------------------------------
module mult8_seq_unit
  import mult8_pkg::*;
#(
  parameter int WIDTH         = MULT_WIDTH,
  parameter int BITS_PER_STEP = MULT_BPS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int STEPS = WIDTH / BITS_PER_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int PW    = 2 * WIDTH;
  localparam int PP_W  = WIDTH + BITS_PER_STEP;
  // Wide enough to hold any shift up to PW-1 without truncation.
  localparam int SH_W  = $clog2(PW) + 1;

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         a_q, b_q;
  logic [PW-1:0]            acc_q;
  logic [PW-1:0]            product_q;

  logic                     load_s;
  logic                     step_en_s;
  logic [CNT_W-1:0]         step_s;
  logic                     last_s;
  logic [SH_W-1:0]          shamt_s;
  logic [BITS_PER_STEP-1:0] digit_s;
  logic [PP_W-1:0]          pp_s;
  logic [PW-1:0]            acc_sum_s;

  mult_step_cnt #(
    .STEPS (STEPS)
  ) u_step_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_s),
    .en   (step_en_s),
    .cnt  (step_s),
    .last (last_s)
  );

  // Current multiplier digit and its weighted partial product. The partial
  // product fits in WIDTH+BITS_PER_STEP bits, and the accumulated sum never
  // exceeds a*b, so the 2*WIDTH accumulator cannot overflow.
  assign shamt_s   = SH_W'(step_s) * SH_W'(BITS_PER_STEP);
  assign digit_s   = BITS_PER_STEP'(b_q >> shamt_s);
  assign pp_s      = {{BITS_PER_STEP{1'b0}}, a_q} * {{WIDTH{1'b0}}, digit_s};
  assign acc_sum_s = acc_q + (PW'(pp_s) << shamt_s);

  // Next-state and control decode for the IDLE -> CALC -> DONE controller.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    step_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load_s  = 1'b1;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        step_en_s = 1'b1;
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand, accumulator and product registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      acc_q     <= {PW{1'b0}};
      product_q <= {PW{1'b0}};
    end else begin
      state_q <= state_d;
      if (load_s) begin
        a_q   <= a;
        b_q   <= b;
        acc_q <= {PW{1'b0}};
      end else if (step_en_s) begin
        acc_q <= acc_sum_s;
      end else begin
        acc_q <= acc_q;
      end
      // The final step's sum goes straight to the output register so the
      // product is valid in the same cycle DONE is entered.
      if (step_en_s && last_s) begin
        product_q <= acc_sum_s;
      end else begin
        product_q <= product_q;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign product   = product_q;

endmodule : mult8_seq_unit
